muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
- REQ-001: Parameter EARLY_OUT, default 1; when 1, divide-by-zero and signed-overflow divides finish via a short path; when 0, all operations take full latency.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: start  input  1  request strobe; sampled only in IDLE.
- REQ-005: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- REQ-006: rs1_val  input  32  operand A, from register file RD1.
- REQ-007: rs2_val  input  32  operand B, from register file RD2.
- REQ-008: rd_addr  input  5  destination register index.
- REQ-009: busy  output  1  high whenever state is not IDLE.
- REQ-010: done  output  1  one-cycle pulse when result is valid.
- REQ-011: result  output  32  operation result; drives register-file write data (WD3).
- REQ-012: rd_out  output  5  captured rd_addr; drives register-file write address (A3).
- REQ-013: we  output  1  write enable to register file (WE3); identical to done, except forced 0 when rd_out == 0.

Function
- REQ-014: States are IDLE, CALC and DONE.
- REQ-015: IDLE with start=1 latches funct3, both operands and rd_addr, then goes to CALC; a short-path op with EARLY_OUT=1 goes to DONE instead.
- REQ-016: CALC runs exactly 32 iteration cycles, tracked by a 6-bit counter, then goes to DONE.
- REQ-017: DONE lasts one cycle with done=1, then returns to IDLE unconditionally.
- REQ-018: start in CALC or DONE is ignored; there is no queuing and latched operands are unaffected.
- REQ-019: Latency from the start-sampling edge to done high: 33 cycles on the normal path, 1 cycle on the short path.
- REQ-020: Multiply is shift-add over a 64-bit product of operand magnitudes, with sign fixed after the last iteration.
- REQ-021: Multiply signedness: MUL/MULH treat both operands as signed; MULHSU treats A signed and B unsigned; MULHU treats both unsigned.
- REQ-022: Multiply result selection: MUL returns product[31:0]; the MULH* ops return product[63:32].
- REQ-023: Divide is a restoring divide on magnitudes; the quotient is negated if the operand signs differ (DIV), and the remainder takes the sign of the dividend (REM).
- REQ-024: Divide by zero: DIV/DIVU return 32'hFFFFFFFF; REM/REMU return rs1_val unchanged.
- REQ-025: Signed overflow (DIV/REM with A=32'h80000000, B=32'hFFFFFFFF): DIV returns 32'h80000000; REM returns 0.
- REQ-026: Results of REQ-024 and REQ-025 are identical whether EARLY_OUT is 0 or 1.
- REQ-027: result and rd_out update only on entry to DONE and hold until the next DONE.
- REQ-028: done, we and busy are registered outputs with no combinational path from any input.

Reset
- REQ-029: rst_n low forces IDLE and clears counter, result, rd_out, done, we and busy to 0 immediately, without waiting for clk.
- REQ-030: Reset asserted mid-CALC abandons the operation with no done or we pulse, then or afterwards.
- REQ-031: After rst_n deasserts, the first start is accepted on the first rising edge that samples start=1.

Verification
- REQ-032: MUL 7 x 6, rd_addr=5 -> done at cycle 33, result=42, rd_out=5, we=1.
- REQ-033: MULH with rs1=32'hFFFFFFFF (-1) and rs2=2 -> result=32'hFFFFFFFF; MULHU with the same operands -> result=1.
- REQ-034: DIV -7/2 -> result=-3 (32'hFFFFFFFD); REM -7/2 -> result=-1; DIVU 12/7 -> result=1; REMU 12/7 -> result=5.
- REQ-035: DIVU 9/0 with EARLY_OUT=1 -> done 1 cycle after start, result=32'hFFFFFFFF; REMU 9/0 -> result=9; DIV 32'h80000000 / -1 -> result=32'h80000000.
- REQ-036: Second start pulse at cycle 10 of CALC -> ignored; exactly one done at cycle 33 carrying the first operation's result.
- REQ-037: rst_n low at cycle 15 of CALC -> busy=0 immediately, no done/we within 40 following cycles; a new MUL 3 x 3 issued after release completes with result=9.
- REQ-038: Any op with rd_addr=0 -> done=1, we=0.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the RV32M multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, result, rd_out, we
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, result, rd_out, we
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with an optional one-cycle path for divide-by-zero and overflow.
module muldiv_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  mdu
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ALL_ONES  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0]  INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [2:0]            r_op;
  logic [XLEN-1:0]       r_a;
  logic [XLEN-1:0]       r_mag;
  logic [4:0]            r_rd;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_div0;
  logic                  r_ovf;
  logic [2*XLEN-1:0]     r_prod;
  logic [CNT_W-1:0]      r_cnt;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_we;
  logic [XLEN-1:0]       r_result;
  logic [4:0]            r_rd_out;

  logic                  w_accept;
  logic                  w_iter;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_we_nxt;
  logic [XLEN-1:0]       w_res_nxt;
  logic [4:0]            w_rd_nxt;

  // Decode of the request currently on the inputs
  logic                  w_in_div;
  logic                  w_in_a_signed;
  logic                  w_in_b_signed;
  logic                  w_in_a_neg;
  logic                  w_in_b_neg;
  logic [XLEN-1:0]       w_in_mag_a;
  logic [XLEN-1:0]       w_in_mag_b;
  logic                  w_in_div0;
  logic                  w_in_ovf;
  logic                  w_in_short;
  logic [XLEN-1:0]       w_in_special_res;

  assign w_in_div      = mdu.funct3[2];
  assign w_in_a_signed = w_in_div ? ~mdu.funct3[0] : (mdu.funct3 != 3'b011);
  assign w_in_b_signed = w_in_div ? ~mdu.funct3[0] : (mdu.funct3[1:0] == 2'b00 || mdu.funct3[1:0] == 2'b01);
  assign w_in_a_neg    = w_in_a_signed & mdu.rs1_val[XLEN-1];
  assign w_in_b_neg    = w_in_b_signed & mdu.rs2_val[XLEN-1];
  assign w_in_mag_a    = w_in_a_neg ? XLEN'(~mdu.rs1_val + 32'd1) : mdu.rs1_val;
  assign w_in_mag_b    = w_in_b_neg ? XLEN'(~mdu.rs2_val + 32'd1) : mdu.rs2_val;
  assign w_in_div0     = w_in_div & (mdu.rs2_val == '0);
  assign w_in_ovf      = w_in_div & ~mdu.funct3[0] & (mdu.rs1_val == INT_MIN) & (mdu.rs2_val == ALL_ONES);
  assign w_in_short    = EARLY_OUT & (w_in_div0 | w_in_ovf);
  assign w_in_special_res = w_in_div0 ? (mdu.funct3[1] ? mdu.rs1_val : ALL_ONES)
                                      : (mdu.funct3[1] ? '0 : INT_MIN);

  // One iteration of shift-add multiply (hi accumulates, multiplier shifts out of lo)
  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_mul_step;
  assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_mag : '0)};
  assign w_mul_step = {w_mul_sum, r_prod[XLEN-1:1]};

  // One iteration of restoring divide: hi is the partial remainder, lo the dividend/quotient
  logic [XLEN:0]         w_div_shift;
  logic                  w_div_ge;
  logic [XLEN-1:0]       w_div_sub;
  logic [2*XLEN-1:0]     w_div_step;
  assign w_div_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag});
  assign w_div_sub   = XLEN'(w_div_shift - {1'b0, r_mag});
  assign w_div_step  = w_div_ge ? {w_div_sub, r_prod[XLEN-2:0], 1'b1}
                                : {w_div_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0]     w_prod_nxt;
  assign w_prod_nxt = r_op[2] ? w_div_step : w_mul_step;

  // Sign fix-up and result selection from the final product/quotient/remainder
  logic [2*XLEN-1:0]     w_prod_fix;
  logic [XLEN-1:0]       w_quo_fix;
  logic [XLEN-1:0]       w_rem_fix;
  logic [XLEN-1:0]       w_calc_res;
  assign w_prod_fix = r_neg_q ? (2*XLEN)'(~w_prod_nxt + 64'd1) : w_prod_nxt;
  assign w_quo_fix  = r_neg_q ? XLEN'(~w_prod_nxt[XLEN-1:0] + 32'd1) : w_prod_nxt[XLEN-1:0];
  assign w_rem_fix  = r_neg_r ? XLEN'(~w_prod_nxt[2*XLEN-1:XLEN] + 32'd1) : w_prod_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_calc_res = '0;
    if (r_div0) begin
      w_calc_res = r_op[1] ? r_a : ALL_ONES;
    end else if (r_ovf) begin
      w_calc_res = r_op[1] ? '0 : INT_MIN;
    end else if (r_op[2]) begin
      w_calc_res = r_op[1] ? w_rem_fix : w_quo_fix;
    end else begin
      w_calc_res = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mdu.start) begin
          w_state_nxt = w_in_short ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered status and result outputs
  always_comb begin
    w_accept   = 1'b0;
    w_iter     = 1'b0;
    w_res_nxt  = w_calc_res;
    w_rd_nxt   = r_rd;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
    case (r_state)
      S_IDLE: begin
        w_accept  = mdu.start;
        w_res_nxt = w_in_special_res;
        w_rd_nxt  = mdu.rd_addr;
      end
      S_CALC:  w_iter = 1'b1;
      default: ;
    endcase
    w_we_nxt = w_done_nxt & (w_rd_nxt != '0);
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_mag    <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= mdu.funct3;
        r_a     <= mdu.rs1_val;
        r_mag   <= w_in_div ? w_in_mag_b : w_in_mag_a;
        r_rd    <= mdu.rd_addr;
        r_neg_q <= w_in_a_neg ^ w_in_b_neg;
        r_neg_r <= w_in_a_neg;
        r_div0  <= w_in_div0;
        r_ovf   <= w_in_ovf;
        r_prod  <= {{XLEN{1'b0}}, (w_in_div ? w_in_mag_a : w_in_mag_b)};
        r_cnt   <= '0;
      end else if (w_iter) begin
        r_prod  <= w_prod_nxt;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_we   <= w_we_nxt;
      if (w_done_nxt) begin
        r_result <= w_res_nxt;
        r_rd_out <= w_rd_nxt;
      end
    end
  end

  assign mdu.busy   = r_busy;
  assign mdu.done   = r_done;
  assign mdu.we     = r_we;
  assign mdu.result = r_result;
  assign mdu.rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit; runs an EARLY_OUT=1 and an EARLY_OUT=0 instance side by side.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  muldiv_if if_e ();
  muldiv_if if_f ();

  muldiv_unit #(.EARLY_OUT(1'b1)) u_early (.clk(clk), .rst_n(rst_n), .mdu(if_e.slave));
  muldiv_unit #(.EARLY_OUT(1'b0)) u_full  (.clk(clk), .rst_n(rst_n), .mdu(if_f.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    if_e.start = st; if_e.funct3 = f; if_e.rs1_val = a; if_e.rs2_val = b; if_e.rd_addr = rd;
    if_f.start = st; if_f.funct3 = f; if_f.rs1_val = a; if_f.rs2_val = b; if_f.rd_addr = rd;
  endtask

  // Called just after a rising edge; issues one op and watches both units for 36 cycles.
  task automatic apply(input vec_t v, input int second_at);
    int          lat_e = 0, lat_f = 0, nd_e = 0, nd_f = 0, nwe_e = 0;
    logic [31:0] res_e = '0, res_f = '0;
    logic [4:0]  rdo_e = '0;
    logic        busy1 = 1'b0;
    drive(1'b1, v.f, v.a, v.b, v.rd);
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        drive(1'b0, v.f, v.a, v.b, v.rd);
        busy1 = if_f.busy;
      end
      if (if_e.done) begin
        nd_e++;
        if (lat_e == 0) begin lat_e = c; res_e = if_e.result; rdo_e = if_e.rd_out; end
      end
      if (if_e.we) nwe_e++;
      if (if_f.done) begin
        nd_f++;
        if (lat_f == 0) begin lat_f = c; res_f = if_f.result; end
      end
      if (second_at != 0 && c == second_at) drive(1'b1, 3'b000, 32'd2, 32'd2, 5'd7);
      if (second_at != 0 && c == second_at + 1) drive(1'b0, 3'b000, 32'd2, 32'd2, 5'd7);
    end
    check($sformatf("res_early f=%0d rd=%0d", v.f, v.rd), res_e, v.exp_res);
    check($sformatf("lat_early f=%0d rd=%0d", v.f, v.rd), 32'(lat_e), 32'(v.exp_lat));
    check($sformatf("ndone_early rd=%0d", v.rd), 32'(nd_e), 32'd1);
    check($sformatf("nwe_early rd=%0d", v.rd), 32'(nwe_e), (v.rd != 5'd0) ? 32'd1 : 32'd0);
    check($sformatf("rd_out_early rd=%0d", v.rd), 32'(rdo_e), 32'(v.rd));
    check($sformatf("res_full f=%0d rd=%0d", v.f, v.rd), res_f, v.exp_res);
    check($sformatf("lat_full rd=%0d", v.rd), 32'(lat_f), 32'd33);
    check($sformatf("ndone_full rd=%0d", v.rd), 32'(nd_f), 32'd1);
    check($sformatf("busy_full_c1 rd=%0d", v.rd), 32'(busy1), 32'd1);
    check($sformatf("busy_idle_end rd=%0d", v.rd), 32'({if_e.busy, if_f.busy}), 32'd0);
  endtask

  initial begin
    int   ndw;
    vec_t v;
    n_checks = 0;
    n_err    = 0;
    vecs[0]  = '{3'b000, 32'd7,         32'd6,         5'd5,  32'd42,        33};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'd2,         5'd1,  32'hFFFF_FFFF, 33};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'd2,         5'd2,  32'd1,         33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h8000_0000, 33};
    vecs[5]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33};
    vecs[8]  = '{3'b101, 32'd12,        32'd7,         5'd9,  32'd1,         33};
    vecs[9]  = '{3'b111, 32'd12,        32'd7,         5'd10, 32'd5,         33};
    vecs[10] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33};
    vecs[11] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         33};
    vecs[12] = '{3'b101, 32'd9,         32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    vecs[13] = '{3'b111, 32'd9,         32'd0,         5'd14, 32'd9,         1};
    vecs[14] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, 1};
    vecs[15] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1};
    vecs[16] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1};
    vecs[17] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,         33};
    vecs[18] = '{3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        33};
    vecs[19] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         5'd19, 32'hFFFF_FFFF, 1};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    check("rst_busy",   32'(if_e.busy),   32'd0);
    check("rst_done",   32'(if_e.done),   32'd0);
    check("rst_we",     32'(if_e.we),     32'd0);
    check("rst_result", if_e.result,      32'd0);
    check("rst_rd_out", 32'(if_e.rd_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) apply(vecs[i], 0);

    // A second start during CALC must be ignored
    v = '{3'b000, 32'd5, 32'd5, 5'd3, 32'd25, 33};
    apply(v, 10);

    // Reset in the middle of CALC abandons the operation
    drive(1'b1, 3'b000, 32'd8, 32'd8, 5'd4);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b0, 3'b000, 32'd8, 32'd8, 5'd4);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy_now", 32'({if_e.busy, if_f.busy}), 32'd0);
    check("midrst_done_now", 32'({if_e.done, if_f.done}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ndw = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if_e.done || if_e.we || if_f.done || if_f.we) ndw++;
    end
    check("midrst_no_done_we", 32'(ndw), 32'd0);
    v = '{3'b000, 32'd3, 32'd3, 5'd9, 32'd9, 33};
    apply(v, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
